// File: rtl/image_load_reader.sv
// rtl/image_load_reader.sv - Avalon-MM frame reader emitting one Avalon-ST video packet per start pulse
// Define IMAGE_LOAD_DONE_IRQ_EN to add the sticky irq_done output and its irq_clr input.
module image_load_reader #(
  parameter int DATA_WIDTH     = 10,
  parameter int AVM_WIDTH_LOG  = 4,
  parameter int STORE_WIDTH    = 4,
  parameter int FIFO_DEPTH_LOG = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic [31:0]                   avm_address,
  output logic                          avm_read,
  input  logic [(1<<AVM_WIDTH_LOG)-1:0] avm_readdata,
  input  logic                          avm_waitrequest,
  input  logic                          avm_readdatavalid,
  output logic [DATA_WIDTH-1:0]         dout_data,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          dout_startofpacket,
  output logic                          dout_endofpacket,
  input  logic                          sig_en,
  input  logic [31:0]                   sig_address,
  input  logic [31:0]                   sig_image_cnt,
  output logic                          sig_busy
`ifdef IMAGE_LOAD_DONE_IRQ_EN
  ,
  output logic                          irq_done,
  input  logic                          irq_clr
`endif
);

  localparam int W       = 1 << AVM_WIDTH_LOG;
  localparam int PPW     = W / STORE_WIDTH;
  localparam int PPW_LOG = $clog2(PPW);
  localparam int PIX_W   = (PPW_LOG > 0) ? PPW_LOG : 1;
  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG;
  localparam int CNT_W   = FIFO_DEPTH_LOG + 1;
  localparam int SUM_W   = FIFO_DEPTH_LOG + 2;
  localparam logic [31:0] STRIDE = 32'(W / 8);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [31:0]          frame_words;
  logic [31:0]          words_issued;
  logic [31:0]          pixels_left;
  logic [CNT_W-1:0]     outstanding;
  logic [CNT_W-1:0]     fifo_count;
  logic [FIFO_DEPTH_LOG-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG-1:0] rd_ptr;
  logic [PIX_W-1:0]     pix_idx;
  logic [W-1:0]         fifo_mem [DEPTH];

  logic                 start;
  logic                 fifo_empty;
  logic                 rd_accept;
  logic                 push;
  logic                 pix_beat;
  logic                 last_pix;
  logic                 pop;
  logic                 eop_accept;
  logic [SUM_W-1:0]     in_flight;
  logic                 room;
  logic [32:0]          words_sum;
  logic [W-1:0]         head_word;
  logic [STORE_WIDTH-1:0] head_pix;

  assign start      = (state == IDLE) && sig_en && (sig_image_cnt != 32'd0);
  assign fifo_empty = (fifo_count == '0);
  assign rd_accept  = avm_read && !avm_waitrequest;
  // Returns with nothing outstanding are leftovers from before a reset.
  assign push       = avm_readdatavalid && (outstanding != '0);
  assign pix_beat   = (state == DATA) && dout_valid && dout_ready;
  assign last_pix   = (pixels_left == 32'd1);
  assign pop        = pix_beat && (last_pix || (pix_idx == PIX_W'(PPW - 1)));
  assign eop_accept = pix_beat && last_pix;

  // Issue is throttled by reserved FIFO space, so every return always fits.
  assign in_flight  = SUM_W'(outstanding) + SUM_W'(fifo_count);
  assign room       = in_flight < SUM_W'(DEPTH);
  assign avm_read   = (state != IDLE) && (words_issued < frame_words) && room;

  assign words_sum  = {1'b0, sig_image_cnt} + 33'(PPW - 1);
  assign head_word  = fifo_mem[rd_ptr];
  assign head_pix   = head_word[int'(pix_idx) * STORE_WIDTH +: STORE_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = HDR;
      HDR:     if (dout_ready) state_nxt = DATA;
      DATA:    if (eop_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dout_valid         = 1'b0;
    dout_data          = '0;
    dout_startofpacket = 1'b0;
    dout_endofpacket   = 1'b0;
    sig_busy           = (state != IDLE);
    case (state)
      HDR: begin
        dout_valid         = 1'b1;
        dout_startofpacket = 1'b1;
      end
      DATA: begin
        if (!fifo_empty) begin
          dout_valid       = 1'b1;
          dout_data        = DATA_WIDTH'(head_pix);
          dout_endofpacket = last_pix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avm_address  <= 32'd0;
      frame_words  <= 32'd0;
      words_issued <= 32'd0;
    end else if (start) begin
      avm_address  <= sig_address;
      frame_words  <= 32'(words_sum >> PPW_LOG);
      words_issued <= 32'd0;
    end else if (rd_accept) begin
      avm_address  <= avm_address + STRIDE;
      words_issued <= words_issued + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (rd_accept && !push) begin
      outstanding <= outstanding + 1'b1;
    end else if (push && !rd_accept) begin
      outstanding <= outstanding - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (push && !pop) begin
        fifo_count <= fifo_count + 1'b1;
      end else if (pop && !push) begin
        fifo_count <= fifo_count - 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= avm_readdata;
  end

  // A partial last word is dropped by popping it together with the eop pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixels_left <= 32'd0;
      pix_idx     <= '0;
    end else if (start) begin
      pixels_left <= sig_image_cnt;
      pix_idx     <= '0;
    end else if (pix_beat) begin
      pixels_left <= pixels_left - 32'd1;
      pix_idx     <= pop ? '0 : pix_idx + 1'b1;
    end
  end

`ifdef IMAGE_LOAD_DONE_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_done <= 1'b0;
    end else if (eop_accept) begin
      irq_done <= 1'b1;
    end else if (irq_clr) begin
      irq_done <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_image_load_reader.sv
// tb/tb_image_load_reader.sv - self-checking bench for image_load_reader (table vectors plus random frames)
`timescale 1ns/1ps
module tb_image_load_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [15:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
  logic [9:0]  dout_data;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_startofpacket;
  logic        dout_endofpacket;
  logic        sig_en;
  logic [31:0] sig_address;
  logic [31:0] sig_image_cnt;
  logic        sig_busy;
`ifdef IMAGE_LOAD_DONE_IRQ_EN
  logic        irq_done;
  logic        irq_clr;
`endif

  always #5 clk = ~clk;

  image_load_reader dut (
    .clk(clk), .rst(rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket),
    .sig_en(sig_en), .sig_address(sig_address), .sig_image_cnt(sig_image_cnt),
    .sig_busy(sig_busy)
`ifdef IMAGE_LOAD_DONE_IRQ_EN
    , .irq_done(irq_done), .irq_clr(irq_clr)
`endif
  );

  typedef struct { logic [15:0] data; int due; } ret_t;
  typedef struct { logic [9:0] data; logic sop; logic eop; } beat_t;
  typedef struct {
    logic [31:0] base; logic [31:0] cnt; int wait_n; int stall_px; int en_at;
    int exp_reads; logic [9:0] exp_last;
  } vec_t;

  ret_t        ret_q[$];
  beat_t       got[$];
  logic [31:0] rd_log[$];
  vec_t        vt[6];

  int          cyc = 0, n_cmp = 0, n_bad = 0;
  int          ready_low = 0, wait_first = 0, stall_seen = 0;
  int          reads_acc = 0, px_acc = 0, max_inflight = 0;
  bit          rand_ready = 0, rand_wait = 0, prev_stall = 0;
  logic [31:0] prev_addr = 0, seed = 0;

  // Memory contents: nibble k of the word at byte address a.
  function automatic logic [15:0] mem_word(input logic [31:0] a);
    logic [15:0] w;
    logic [31:0] b;
    b = ((a >> 1) << 2) + seed;
    for (int k = 0; k < 4; k++) w[k*4 +: 4] = 4'(b + 32'(k) + 32'd1);
    return w;
  endfunction

  function automatic logic [9:0] exp_pixel(input logic [31:0] base, input int i);
    logic [15:0] w;
    w = mem_word(base + 32'(2 * (i / 4)));
    w = w >> ((i % 4) * 4);
    return 10'(w[3:0]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    int inflight;
    @(negedge clk);
    cyc++;
    if (ready_low > 0) begin
      dout_ready = 1'b0;
      ready_low--;
    end else begin
      dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    if (wait_first > 0) avm_waitrequest = 1'b1;
    else avm_waitrequest = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = ret_q[0].data;
      void'(ret_q.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 16'($urandom);
    end
    #1;
    if (prev_stall) begin
      chk("wait_hold_read", 32'(avm_read), 32'd1);
      chk("wait_hold_addr", avm_address, prev_addr);
    end
    prev_stall = avm_read && avm_waitrequest;
    prev_addr  = avm_address;
    if (avm_read && avm_waitrequest) begin
      stall_seen++;
      if (wait_first > 0) wait_first--;
    end
    if (avm_read && !avm_waitrequest) begin
      ret_q.push_back('{data: mem_word(avm_address), due: cyc + 2});
      rd_log.push_back(avm_address);
      reads_acc++;
    end
    if (dout_valid && dout_ready) begin
      got.push_back('{dout_data, dout_startofpacket, dout_endofpacket});
      if (!dout_startofpacket) px_acc++;
    end
    inflight = reads_acc - px_acc / 4;
    if (inflight > max_inflight) max_inflight = inflight;
  endtask

  task automatic run_frame(input string tag, input logic [31:0] base, input logic [31:0] cnt,
                           input int stall_px, input int en_at,
                           output int n_reads, output logic [9:0] last_px);
    int          budget, stall_end, exp_words, n;
    bit          stalled;
    logic [11:0] e, a;
    got.delete(); rd_log.delete();
    reads_acc = 0; px_acc = 0; max_inflight = 0; stall_seen = 0;
    stall_end = -1; stalled = 0; budget = 0;
    sig_address = base; sig_image_cnt = cnt; sig_en = 1'b1;
    step();
    sig_en = 1'b0;
    chk({tag, "_hdr_latency"}, {30'd0, dout_valid, dout_startofpacket}, 32'd3);
    while (!(got.size() > 0 && got[got.size()-1].eop) && budget < 3000) begin
      step();
      budget++;
      if (en_at >= 0 && budget == en_at) begin
        sig_address = 32'h0; sig_image_cnt = 32'd3; sig_en = 1'b1;
        step();
        sig_en = 1'b0;
        budget++;
      end
      if (stall_px >= 0 && !stalled && px_acc >= stall_px) begin
        stalled = 1; ready_low = 10; stall_end = cyc + 10;
      end
      if (cyc == stall_end) begin
        chk({tag, "_read_blocked"}, 32'(avm_read), 32'd0);
        chk({tag, "_inflight_full"}, 32'(reads_acc - px_acc / 4), 32'd8);
      end
    end
    chk({tag, "_eop_seen"}, 32'(budget < 3000), 32'd1);
    chk({tag, "_beats"}, 32'(got.size()), cnt + 32'd1);
    n = (got.size() < int'(cnt) + 1) ? got.size() : int'(cnt) + 1;
    for (int i = 0; i < n; i++) begin
      e = (i == 0) ? 12'b10 : {exp_pixel(base, i - 1), 1'b0, 1'(i == int'(cnt))};
      a = {got[i].data, got[i].sop, got[i].eop};
      chk($sformatf("%s_beat%0d", tag, i), 32'(a), 32'(e));
    end
    exp_words = int'((cnt + 32'd3) / 32'd4);
    chk({tag, "_reads"}, 32'(rd_log.size()), 32'(exp_words));
    for (int k = 0; k < rd_log.size() && k < exp_words; k++)
      chk($sformatf("%s_addr%0d", tag, k), rd_log[k], base + 32'(2 * k));
    step();
    chk({tag, "_busy_clear"}, 32'(sig_busy), 32'd0);
    chk({tag, "_no_outstanding"}, 32'(ret_q.size()), 32'd0);
    chk({tag, "_inflight_bound"}, 32'(max_inflight <= 8), 32'd1);
    n_reads = rd_log.size();
    last_px = (got.size() > 0) ? got[got.size()-1].data : 10'h3ff;
    repeat (4) step();
    chk({tag, "_no_new_packet"}, 32'(got.size()), cnt + 32'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_reads;
    logic [9:0]  last_px;
    logic [31:0] rb, rc;
    rst = 1'b1; sig_en = 1'b0; sig_address = 0; sig_image_cnt = 0;
    avm_readdata = 0; avm_waitrequest = 0; avm_readdatavalid = 0; dout_ready = 1'b1;
`ifdef IMAGE_LOAD_DONE_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    chk("rst_read", 32'(avm_read), 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_data", 32'(dout_data), 0);
    chk("rst_sop_eop", 32'({dout_startofpacket, dout_endofpacket}), 0);
    chk("rst_busy", 32'(sig_busy), 0);
`ifdef IMAGE_LOAD_DONE_IRQ_EN
    chk("rst_irq", 32'(irq_done), 0);
`endif
    rst = 1'b0;

    vt[0] = '{32'h400000,  8, 0, -1, -1,  2, 10'h8};
    vt[1] = '{32'h400000,  5, 0, -1, -1,  2, 10'h5};
    vt[2] = '{32'h400000,  8, 4, -1, -1,  2, 10'h8};
    vt[3] = '{32'h400000, 64, 0, 12, -1, 16, 10'h0};
    vt[4] = '{32'h400000, 32, 0, -1,  6,  8, 10'h0};
    vt[5] = '{32'h400000,  1, 0, -1, -1,  1, 10'h1};
    for (int v = 0; v < 6; v++) begin
      seed = 0; ready_low = 0; wait_first = vt[v].wait_n;
      run_frame($sformatf("vec%0d", v), vt[v].base, vt[v].cnt, vt[v].stall_px, vt[v].en_at,
                n_reads, last_px);
      chk($sformatf("vec%0d_n_reads", v), 32'(n_reads), 32'(vt[v].exp_reads));
      chk($sformatf("vec%0d_last_px", v), 32'(last_px), 32'(vt[v].exp_last));
      chk($sformatf("vec%0d_stalls", v), 32'(stall_seen), 32'(vt[v].wait_n));
    end

    reads_acc = 0; got.delete();
    sig_address = 32'h400000; sig_image_cnt = 0; sig_en = 1'b1;
    step();
    sig_en = 1'b0;
    repeat (3) step();
    chk("zero_cnt_busy", 32'(sig_busy), 0);
    chk("zero_cnt_reads", 32'(reads_acc), 0);
    chk("zero_cnt_beats", 32'(got.size()), 0);

    sig_address = 32'h400000; sig_image_cnt = 32; sig_en = 1'b1;
    step();
    sig_en = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("midrst_read", 32'(avm_read), 0);
    chk("midrst_valid", 32'(dout_valid), 0);
    chk("midrst_busy", 32'(sig_busy), 0);
    chk("midrst_addr", avm_address, 0);
    step();
    rst = 1'b0; prev_stall = 0;
    repeat (4) step();
    chk("stale_valid", 32'(dout_valid), 0);
    chk("stale_busy", 32'(sig_busy), 0);
    chk("stale_read", 32'(avm_read), 0);
    run_frame("after_rst", 32'h400000, 32'd12, -1, -1, n_reads, last_px);
`ifdef IMAGE_LOAD_DONE_IRQ_EN
    chk("irq_set", 32'(irq_done), 1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_cleared", 32'(irq_done), 0);
`endif

    rand_ready = 1; rand_wait = 1;
    for (int r = 0; r < 8; r++) begin
      seed = $urandom;
      rb   = $urandom & 32'hFFFF_FFFE;
      rc   = 32'($urandom_range(1, 40));
      run_frame($sformatf("rnd%0d", r), rb, rc, -1, -1, n_reads, last_px);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
